sync_updown_counter: RTL and testbench

SYNC_UPDOWN_COUNTER -- requirements
Module: sync_updown_counter

---
 rtl/sync_updown_counter.sv | 72 +++++++
 tb/tb_sync_updown_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sync_updown_counter.sv
// Up/down counter with a programmable terminal count, parallel load, and an optional
// saturating mode. A sticky flag records every wrap until the next load or reset.
module sync_updown_counter #(
  parameter int unsigned         WIDTH    = 4,
  parameter logic [WIDTH-1:0]    MAX      = {WIDTH{1'b1}},
  parameter bit                  SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrapped
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrapped_reg;
  logic             wrapped_next;
  logic             at_top;
  logic             at_bottom;
  logic [WIDTH-1:0] load_clamped;

  assign at_top       = (count_reg == MAX);
  assign at_bottom    = (count_reg == '0);
  // Loads above the terminal count are clamped so out never exceeds MAX.
  assign load_clamped = (load_val > MAX) ? MAX : load_val;

  always_comb begin
    count_next   = count_reg;
    wrapped_next = wrapped_reg;
    if (load) begin
      count_next   = load_clamped;
      wrapped_next = 1'b0;
    end else if (en) begin
      if (up) begin
        if (!at_top) begin
          count_next = count_reg + WIDTH'(1);
        end else if (!SATURATE) begin
          count_next   = '0;
          wrapped_next = 1'b1;
        end
      end else begin
        if (!at_bottom) begin
          count_next = count_reg - WIDTH'(1);
        end else if (!SATURATE) begin
          count_next   = MAX;
          wrapped_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg   <= '0;
      wrapped_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      wrapped_reg <= wrapped_next;
    end
  end

  assign out     = count_reg;
  assign wrapped = wrapped_reg;
  // Flags the step that is about to cross a boundary, before the edge happens.
  assign tc      = en & ~load & ((up & at_top) | (~up & at_bottom));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter: a wrapping and a saturating instance share stimulus;
// each vector queues its hand-computed result and a monitor process checks it.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] out_w, out_s;
  logic       tc_w, tc_s, wr_w, wr_s;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         sel;      // 0 = wrapping instance, 1 = saturating instance
    bit         exp_tc;   // before the edge
    logic [3:0] exp_out;  // after the edge
    bit         exp_wr;   // after the edge
    int         id;
  } entry_t;

  entry_t q[$];
  int     vec_id = 0;

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out_w), .tc(tc_w), .wrapped(wr_w)
  );

  sync_updown_counter #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out_s), .tc(tc_s), .wrapped(wr_s)
  );

  function automatic void chk(string name, int id, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%0d required=%0d", name, id, act, exp);
    end else begin
      $display("ok   %s vec=%0d value=%0d", name, id, act);
    end
  endfunction

  task automatic step(input bit s, input bit e, input bit u, input bit l, input int lv,
                      input bit etc, input int eout, input bit ewr);
    entry_t x;
    @(negedge clk);
    en = e; up = u; load = l; load_val = 4'(lv);
    x.sel = s; x.exp_tc = etc; x.exp_out = 4'(eout); x.exp_wr = ewr; x.id = vec_id;
    vec_id++;
    q.push_back(x);
  endtask

  // Asserts reset between clock edges and checks the asynchronous clear.
  task automatic pulse_reset();
    @(posedge clk);
    #3;
    en = 1'b0; load = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_out_w", -1, int'(out_w), 0);
    chk("rst_wr_w", -1, int'(wr_w), 0);
    chk("rst_out_s", -1, int'(out_s), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: tc before the edge, out/wrapped just after it.
  initial begin
    entry_t x;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("tc", x.id, x.sel ? int'(tc_s) : int'(tc_w), int'(x.exp_tc));
        @(posedge clk);
        #1;
        chk("out", x.id, x.sel ? int'(out_s) : int'(out_w), int'(x.exp_out));
        chk("wrapped", x.id, x.sel ? int'(wr_s) : int'(wr_w), int'(x.exp_wr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Held in reset: outputs zero regardless of clock, tc follows out=0.
    en = 1'b1; up = 1'b0; load = 1'b1; load_val = 4'd7;
    #2;
    chk("inrst_out", -1, int'(out_w), 0);
    chk("inrst_wr", -1, int'(wr_w), 0);
    chk("inrst_tc_load", -1, int'(tc_w), 0);
    load = 1'b0;
    #1;
    chk("inrst_tc", -1, int'(tc_w), 1);
    #5;
    chk("inrst_edge_out", -1, int'(out_w), 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Count up through the wrap.
    for (int i = 1; i <= 9; i++) step(0, 1, 1, 0, 0, 0, i, 0);
    step(0, 1, 1, 0, 0, 1, 0, 1);
    step(0, 1, 1, 0, 0, 0, 1, 1);
    step(0, 1, 1, 0, 0, 0, 2, 1);

    // Count down from reset wraps to MAX.
    pulse_reset();
    step(0, 1, 0, 0, 0, 1, 9, 1);
    step(0, 1, 0, 0, 0, 0, 8, 1);
    step(0, 1, 0, 0, 0, 0, 7, 1);

    // Load clamps, clears wrapped, and overrides en/up.
    step(0, 1, 1, 1, 15, 0, 9, 0);
    step(0, 1, 1, 0, 0, 1, 0, 1);

    // Direction toggling, then hold.
    step(0, 0, 0, 1, 5, 0, 5, 0);
    step(0, 1, 0, 0, 0, 0, 4, 0);
    step(0, 1, 1, 0, 0, 0, 5, 0);
    step(0, 1, 0, 0, 0, 0, 4, 0);
    step(0, 1, 1, 0, 0, 0, 5, 0);
    step(0, 0, 1, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);

    // Saturating instance holds at both boundaries.
    step(1, 0, 1, 1, 8, 0, 8, 0);
    step(1, 1, 1, 0, 0, 0, 9, 0);
    step(1, 1, 1, 0, 0, 1, 9, 0);
    step(1, 1, 1, 0, 0, 1, 9, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0);

    // Reset mid-count, then resume from zero.
    step(0, 0, 1, 1, 6, 0, 6, 0);
    pulse_reset();
    step(0, 1, 1, 0, 0, 0, 1, 0);

    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
